// File: rtl/inst_queue_if.sv
// Instruction queue bundle/issue interface: fetch-side bundle push plus
// decode-side head issue handshake and occupancy.
interface inst_queue_if #(
    parameter int unsigned DEPTH = 8
);
    logic                      flush;
    logic                      ID_inst_en;
    logic [31:0]               ID_PC;
    logic [31:0]               ID_inst1;
    logic [31:0]               ID_inst2;
    logic [31:0]               ID_inst3;
    logic [31:0]               ID_inst4;
    logic                      stall;
    logic                      issue_ready;
    logic                      issue_valid;
    logic [31:0]               issue_inst;
    logic [31:0]               issue_PC;
    logic [$clog2(DEPTH):0]    count;

    // Queue side
    modport slave (
        input  flush, ID_inst_en, ID_PC, ID_inst1, ID_inst2, ID_inst3, ID_inst4,
        input  issue_ready,
        output stall, issue_valid, issue_inst, issue_PC, count
    );

    // Fetch/decode side
    modport master (
        output flush, ID_inst_en, ID_PC, ID_inst1, ID_inst2, ID_inst3, ID_inst4,
        output issue_ready,
        input  stall, issue_valid, issue_inst, issue_PC, count
    );
endinterface

// File: rtl/inst_queue.sv
// Instruction queue: circular FIFO accepting 4-instruction bundles and
// issuing one instruction per cycle in program order.
module inst_queue #(
    parameter int unsigned DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    inst_queue_if.slave  q
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   mem_inst [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          stall_c;
    logic          valid_c;
    logic          push;
    logic          pop;
    logic [31:0]   slot_inst [4];

    // Occupancy-derived handshake and head outputs; stall looks only at current count
    always_comb begin
        stall_c       = (count_q > CW'(DEPTH - 4));
        valid_c       = (count_q != '0);
        push          = q.ID_inst_en && !stall_c && !q.flush;
        pop           = valid_c && q.issue_ready && !q.flush;
        slot_inst[0]  = q.ID_inst1;
        slot_inst[1]  = q.ID_inst2;
        slot_inst[2]  = q.ID_inst3;
        slot_inst[3]  = q.ID_inst4;
        q.stall       = stall_c;
        q.issue_valid = valid_c;
        q.issue_inst  = valid_c ? mem_inst[head_q] : '0;
        q.issue_PC    = valid_c ? mem_pc[head_q]   : '0;
        q.count       = count_q;
    end

    // Next pointer/count; flush discards any same-cycle push and pop
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (q.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PW'(4);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + (push ? CW'(4) : '0) - (pop ? CW'(1) : '0);
        end
    end

    // Pointer and count state, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Bundle write into storage; array is not reset since outputs are gated by valid
    always_ff @(posedge clk) begin
        if (push) begin
            for (int unsigned k = 0; k < 4; k++) begin
                mem_inst[tail_q + PW'(k)] <= slot_inst[k];
                mem_pc[tail_q + PW'(k)]   <= q.ID_PC + 32'(4 * k);
            end
        end
    end
endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue (DEPTH=8).
module tb_inst_queue;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    inst_queue_if #(.DEPTH(8)) qif ();

    inst_queue #(.DEPTH(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .q   (qif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bundle(input logic [31:0] pc, input logic [31:0] i1,
                              input logic [31:0] i2, input logic [31:0] i3,
                              input logic [31:0] i4);
        qif.ID_inst_en = 1'b1;
        qif.ID_PC      = pc;
        qif.ID_inst1   = i1;
        qif.ID_inst2   = i2;
        qif.ID_inst3   = i3;
        qif.ID_inst4   = i4;
    endtask

    task automatic check_head(input string tag, input logic [31:0] inst, input logic [31:0] pc);
        check({tag, "_valid"}, {31'd0, qif.issue_valid}, 32'd1);
        check({tag, "_inst"}, qif.issue_inst, inst);
        check({tag, "_pc"}, qif.issue_PC, pc);
    endtask

    logic [31:0] exp_inst [7];
    logic [31:0] exp_pc   [4];

    initial begin
        n_checks         = 0;
        n_errors         = 0;
        rst              = 1'b0;
        qif.flush        = 1'b0;
        qif.ID_inst_en   = 1'b0;
        qif.ID_PC        = '0;
        qif.ID_inst1     = '0;
        qif.ID_inst2     = '0;
        qif.ID_inst3     = '0;
        qif.ID_inst4     = '0;
        qif.issue_ready  = 1'b0;

        // Reset state
        #2;
        check("rst_valid", {31'd0, qif.issue_valid}, 32'd0);
        check("rst_inst", qif.issue_inst, 32'd0);
        check("rst_pc", qif.issue_PC, 32'd0);
        check("rst_stall", {31'd0, qif.stall}, 32'd0);
        check("rst_count", {28'd0, qif.count}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Basic push then four consecutive issues
        set_bundle(32'h0040_0000, 32'h11, 32'h22, 32'h33, 32'h44);
        qif.issue_ready = 1'b1;
        step();
        qif.ID_inst_en = 1'b0;
        check("b_count", {28'd0, qif.count}, 32'd4);
        check_head("b0", 32'h11, 32'h0040_0000);
        step();
        check_head("b1", 32'h22, 32'h0040_0004);
        step();
        check_head("b2", 32'h33, 32'h0040_0008);
        step();
        check_head("b3", 32'h44, 32'h0040_000C);
        step();
        check("b_empty_valid", {31'd0, qif.issue_valid}, 32'd0);
        check("b_empty_inst", qif.issue_inst, 32'd0);

        // Fill to DEPTH, hold third bundle, drain until it is accepted
        qif.issue_ready = 1'b0;
        set_bundle(32'h100, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
        step();
        check("f_count4", {28'd0, qif.count}, 32'd4);
        check("f_stall4", {31'd0, qif.stall}, 32'd0);
        set_bundle(32'h200, 32'hB1, 32'hB2, 32'hB3, 32'hB4);
        step();
        check("f_count8", {28'd0, qif.count}, 32'd8);
        check("f_stall8", {31'd0, qif.stall}, 32'd1);
        set_bundle(32'h300, 32'hC1, 32'hC2, 32'hC3, 32'hC4);
        step();
        check("f_held_count", {28'd0, qif.count}, 32'd8);
        check_head("f_held", 32'hA1, 32'h100);
        qif.issue_ready = 1'b1;
        step();
        check("f_count7", {28'd0, qif.count}, 32'd7);
        check("f_stall7", {31'd0, qif.stall}, 32'd1);
        step();
        step();
        check("f_count5", {28'd0, qif.count}, 32'd5);
        check("f_stall5", {31'd0, qif.stall}, 32'd1);
        step();
        check("f_count4b", {28'd0, qif.count}, 32'd4);
        check("f_stall4b", {31'd0, qif.stall}, 32'd0);
        check_head("f_headB1", 32'hB1, 32'h200);
        step();
        qif.ID_inst_en = 1'b0;
        check("f_pushpop", {28'd0, qif.count}, 32'd7);
        exp_inst = '{32'hB2, 32'hB3, 32'hB4, 32'hC1, 32'hC2, 32'hC3, 32'hC4};
        for (int i = 0; i < 7; i++) begin
            check($sformatf("f_drain%0d", i), qif.issue_inst, exp_inst[i]);
            step();
        end
        check("f_drained", {28'd0, qif.count}, 32'd0);

        // Stall decided on current count only
        qif.issue_ready = 1'b0;
        set_bundle(32'h400, 32'hD1, 32'hD2, 32'hD3, 32'hD4);
        step();
        qif.issue_ready = 1'b1;
        set_bundle(32'h500, 32'hE1, 32'hE2, 32'hE3, 32'hE4);
        step();
        check("s_count7", {28'd0, qif.count}, 32'd7);
        qif.ID_inst_en = 1'b0;
        step();
        step();
        check("s_count5", {28'd0, qif.count}, 32'd5);
        set_bundle(32'h600, 32'hF1, 32'hF2, 32'hF3, 32'hF4);
        check("s_stall5", {31'd0, qif.stall}, 32'd1);
        step();
        check("s_poponly", {28'd0, qif.count}, 32'd4);
        check("s_stall4", {31'd0, qif.stall}, 32'd0);
        step();
        qif.ID_inst_en = 1'b0;
        check("s_pushpop", {28'd0, qif.count}, 32'd7);
        check_head("s_headE2", 32'hE2, 32'h504);

        // Flush with 6 entries and concurrent push/pop
        step();
        check("x_count6", {28'd0, qif.count}, 32'd6);
        qif.flush = 1'b1;
        set_bundle(32'h700, 32'h71, 32'h72, 32'h73, 32'h74);
        step();
        qif.flush      = 1'b0;
        qif.ID_inst_en = 1'b0;
        check("x_count", {28'd0, qif.count}, 32'd0);
        check("x_valid", {31'd0, qif.issue_valid}, 32'd0);
        check("x_inst", qif.issue_inst, 32'd0);
        qif.issue_ready = 1'b0;
        set_bundle(32'h800, 32'h81, 32'h82, 32'h83, 32'h84);
        step();
        qif.ID_inst_en = 1'b0;
        check("x_count_after", {28'd0, qif.count}, 32'd4);
        check_head("x_head", 32'h81, 32'h800);
        qif.issue_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("x_drained", {28'd0, qif.count}, 32'd0);

        // PC wrap modulo 2^32, zero instruction issued like any other
        qif.issue_ready = 1'b0;
        set_bundle(32'hFFFF_FFF8, 32'h0, 32'h1, 32'h2, 32'h3);
        step();
        qif.ID_inst_en  = 1'b0;
        qif.issue_ready = 1'b1;
        exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        for (int i = 0; i < 4; i++) begin
            check_head($sformatf("w_slot%0d", i), 32'(i), exp_pc[i]);
            step();
        end
        check("w_empty", {31'd0, qif.issue_valid}, 32'd0);

        // Several push/drain rounds to wrap head/tail around the array
        for (int r = 1; r <= 3; r++) begin
            qif.issue_ready = 1'b0;
            set_bundle(32'h1000 * r, 32'h10 * r + 1, 32'h10 * r + 2,
                       32'h10 * r + 3, 32'h10 * r + 4);
            step();
            qif.ID_inst_en  = 1'b0;
            qif.issue_ready = 1'b1;
            for (int k = 0; k < 4; k++) begin
                check_head($sformatf("r%0d_%0d", r, k), 32'(32'h10 * r + k + 1),
                           32'(32'h1000 * r + 4 * k));
                step();
            end
        end
        check("r_empty", {28'd0, qif.count}, 32'd0);

        // Asynchronous reset mid-cycle with 4 entries
        qif.issue_ready = 1'b0;
        set_bundle(32'h900, 32'h91, 32'h92, 32'h93, 32'h94);
        step();
        qif.ID_inst_en = 1'b0;
        check("a_count4", {28'd0, qif.count}, 32'd4);
        #2;
        rst = 1'b0;
        #1;
        check("a_valid", {31'd0, qif.issue_valid}, 32'd0);
        check("a_inst", qif.issue_inst, 32'd0);
        check("a_pc", qif.issue_PC, 32'd0);
        check("a_count", {28'd0, qif.count}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("a_count_rel", {28'd0, qif.count}, 32'd0);
        check("a_stall_rel", {31'd0, qif.stall}, 32'd0);
        set_bundle(32'hA00, 32'hAA1, 32'hAA2, 32'hAA3, 32'hAA4);
        step();
        qif.ID_inst_en = 1'b0;
        check_head("a_first", 32'hAA1, 32'hA00);
        check("a_count_new", {28'd0, qif.count}, 32'd4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning queue entries; legal values 8 or 16.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush  input  1  synchronous queue clear (branch mispredict).
REQ-005 SHALL have port ID_inst_en  input  1  bundle valid from IF/ID register.
REQ-006 SHALL have port ID_PC  input  32  PC of bundle slot 1.
REQ-007 SHALL have ports ID_inst1..ID_inst4  input  32 each  bundle instructions, slot 1 oldest.
REQ-008 SHALL have port stall  output  1  back-pressure to fetch and IF/ID register.
REQ-009 SHALL have port issue_ready  input  1  downstream decode/dispatch accepts head this cycle.
REQ-010 SHALL have port issue_valid  output  1  head entry present.
REQ-011 SHALL have port issue_inst  output  32  head instruction.
REQ-012 SHALL have port issue_PC  output  32  head PC.
REQ-013 SHALL have port count  output  log2(DEPTH)+1  occupied entries.

Function
REQ-014 SHALL be a circular FIFO of DEPTH entries, each {inst[31:0], PC[31:0]}, with head/tail pointers wrapping modulo DEPTH.
REQ-015 SHALL drive stall combinationally high when (DEPTH - count) < 4, using current count only (pop in same cycle ignored).
REQ-016 SHALL push all four slots in one cycle when ID_inst_en=1, stall=0, flush=0.
REQ-017 SHALL store slot k (k=1..4) at tail+k-1 with PC = ID_PC + 4*(k-1), modulo 2^32.
REQ-018 SHALL ignore the bundle when ID_inst_en=0 or stall=1; the held bundle is accepted on the first later cycle with stall=0.
REQ-019 SHALL drive issue_valid = (count != 0) combinationally.
REQ-020 SHALL drive issue_inst/issue_PC from head entry when issue_valid=1, else 32'd0.
REQ-021 SHALL pop one entry when issue_valid=1 and issue_ready=1; issue_ready with empty queue has no effect.
REQ-022 SHALL support simultaneous push and pop: count_next = count + 4 - 1, ordering preserved.
REQ-023 SHALL give push-to-issue latency of one cycle: bundle accepted at edge N appears at head (if queue was empty) after edge N.
REQ-024 SHALL on flush=1 set head=tail=0, count=0 at next edge, discarding same-cycle push and pop.
REQ-025 SHALL never overflow or underflow; count stays within 0..DEPTH.
REQ-026 SHALL issue instructions in strict program order; instruction value 32'd0 is stored and issued like any other.

Reset
REQ-027 SHALL on rst=0 immediately clear head, tail, count to 0, giving issue_valid=0, issue_inst=0, issue_PC=0, stall=0.
REQ-028 SHALL leave storage array unreset; outputs gated by REQ-020.
REQ-029 SHALL abort any in-progress push/pop on reset assertion mid-operation; first accepted bundle after release lands at entry 0.

Verification
REQ-030 Reset then push bundle PC=0x00400000, insts 0x11,0x22,0x33,0x44, issue_ready=1 -> issue 0x11@0x00400000, 0x22@0x00400004, 0x33@0x00400008, 0x44@0x0040000C on 4 consecutive cycles, then issue_valid=0.
REQ-031 DEPTH=8, issue_ready=0, push two bundles -> count=8, stall=1; third bundle with ID_inst_en=1 held not written; after 4 pops count=4, stall=0, third bundle accepted next edge.
REQ-032 count=5, push with issue_ready=1 -> stall=1, no push; count=5 -> wait, stall computed at count=5 so only pop: count=4; next cycle push+pop -> count=7.
REQ-033 Queue holding 6 entries, flush=1 with ID_inst_en=1 and issue_ready=1 -> count=0, issue_valid=0 next cycle, flushed bundle not stored.
REQ-034 Push ID_PC=0xFFFFFFF8 -> slot PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004; pointer wrap after 3 push/pop rounds keeps order.
REQ-035 Assert rst=0 mid-cycle with count=4 -> outputs zero before next clk edge; after release count=0, stall=0.
